hamming_serial_rx: RTL and testbench

HAMMING_SERIAL_RX -- requirements
Module: hamming_serial_rx

---
 rtl/hamming_pkg.sv | 27 ++
 rtl/hamming_secded_dec.sv | 40 ++++
 rtl/hamming_serial_rx.sv | 160 ++++++++++++++++
 tb/tb_hamming_serial_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the serial SECDED Hamming receiver: error classes,
// codeword bit positions and receiver FSM state encoding.
package hamming_pkg;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_CORR   = 2'b01;
    localparam logic [1:0] ERR_UNCORR = 2'b10;

    localparam int unsigned CODE_W = 8;

    // Codeword bit positions; POS_P0 is overall even parity over code[7:1].
    localparam int unsigned POS_P0 = 0;
    localparam int unsigned POS_P1 = 1;
    localparam int unsigned POS_P2 = 2;
    localparam int unsigned POS_D0 = 3;
    localparam int unsigned POS_P4 = 4;
    localparam int unsigned POS_D1 = 5;
    localparam int unsigned POS_D2 = 6;
    localparam int unsigned POS_D3 = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } rx_state_t;

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decoder for the 8-bit extended Hamming(7,4) codeword.
// Produces corrected data, the 3-bit syndrome and the error class.
module hamming_secded_dec
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [3:0]        data_o,
    output logic [2:0]        syndrome_o,
    output logic [1:0]        err_o
);

    logic [2:0]        syn;
    logic              parity;
    logic [CODE_W-1:0] fixed;

    always_comb begin
        syn[2] = code_i[POS_P4] ^ code_i[POS_D1] ^ code_i[POS_D2] ^ code_i[POS_D3];
        syn[1] = code_i[POS_P2] ^ code_i[POS_D0] ^ code_i[POS_D2] ^ code_i[POS_D3];
        syn[0] = code_i[POS_P1] ^ code_i[POS_D0] ^ code_i[POS_D1] ^ code_i[POS_D3];
        parity = ^code_i;
    end

    // A zero syndrome with odd parity indexes bit 0, i.e. the overall parity bit.
    always_comb begin
        fixed = code_i;
        err_o = ERR_NONE;
        if (parity) begin
            fixed = code_i ^ (8'd1 << syn);
            err_o = ERR_CORR;
        end else if (syn != 3'd0) begin
            err_o = ERR_UNCORR;
        end
    end

    always_comb begin
        syndrome_o = syn;
        data_o     = {fixed[POS_D3], fixed[POS_D2], fixed[POS_D1], fixed[POS_D0]};
    end

endmodule

// File: rtl/hamming_serial_rx.sv
// Serial SECDED Hamming receiver: frames start/8 code bits/stop, decodes,
// holds the result under valid/ready and keeps saturating error counters.
module hamming_serial_rx
    import hamming_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_bit,
    input  logic             rx_bit_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic [1:0]       out_err,
    output logic             frame_err,
    output logic             overflow,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    rx_state_t         state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [CODE_W-1:0] shreg_q, shreg_d;

    logic              start_det, shift_en, stop_ok, stop_bad;

    logic              out_valid_q, out_valid_d;
    logic [3:0]        out_data_q, out_data_d;
    logic [2:0]        out_syn_q, out_syn_d;
    logic [1:0]        out_err_q, out_err_d;
    logic              frame_err_q, frame_err_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

    logic [3:0]        dec_data;
    logic [2:0]        dec_syn;
    logic [1:0]        dec_err;
    logic              load, drop;

    hamming_secded_dec u_dec (
        .code_i     (shreg_q),
        .data_o     (dec_data),
        .syndrome_o (dec_syn),
        .err_o      (dec_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_bit_valid && !rx_bit) state_d = DATA;
            DATA:    if (rx_bit_valid && bit_cnt_q == 3'd7) state_d = STOP;
            STOP:    if (rx_bit_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_det = (state_q == IDLE) && rx_bit_valid && !rx_bit;
        shift_en  = (state_q == DATA) && rx_bit_valid;
        stop_ok   = (state_q == STOP) && rx_bit_valid && rx_bit;
        stop_bad  = (state_q == STOP) && rx_bit_valid && !rx_bit;
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        if (start_det) begin
            bit_cnt_d = 3'd0;
        end else if (shift_en) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shreg_d   = {shreg_q[CODE_W-2:0], rx_bit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    // A held result is replaced only if the consumer takes it in the same cycle.
    always_comb begin
        load = stop_ok && (!out_valid_q || out_ready);
        drop = stop_ok && out_valid_q && !out_ready;
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_syn_d    = out_syn_q;
        out_err_d    = out_err_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        frame_err_d  = stop_bad;
        overflow_d   = overflow_q || drop;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = dec_data;
            out_syn_d   = dec_syn;
            out_err_d   = dec_err;
            if (dec_err == ERR_CORR && corr_cnt_q != '1) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if (dec_err == ERR_UNCORR && uncorr_cnt_q != '1) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_syn_q    <= '0;
            out_err_q    <= ERR_NONE;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_syn_q    <= out_syn_d;
            out_err_q    <= out_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    always_comb begin
        out_valid    = out_valid_q;
        out_data     = out_data_q;
        out_syndrome = out_syn_q;
        out_err      = out_err_q;
        frame_err    = frame_err_q;
        overflow     = overflow_q;
        corr_cnt     = corr_cnt_q;
        uncorr_cnt   = uncorr_cnt_q;
    end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Directed bench for hamming_serial_rx: table of frames with hand-decoded
// results plus sequences for backpressure, framing, gaps and mid-frame reset.
module tb_hamming_serial_rx;

    localparam int unsigned CW = 2;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_bit = 1'b1;
    logic          rx_bit_valid = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    out_data;
    logic [2:0]    out_syndrome;
    logic [1:0]    out_err;
    logic          frame_err;
    logic          overflow;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] uncorr_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [CW-1:0] exp_corr = '0;
    logic [CW-1:0] exp_uncorr = '0;

    hamming_serial_rx #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_bit       (rx_bit),
        .rx_bit_valid (rx_bit_valid),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_syndrome (out_syndrome),
        .out_err      (out_err),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .corr_cnt     (corr_cnt),
        .uncorr_cnt   (uncorr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic [3:0] data;
        logic [2:0] syn;
        logic [1:0] err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap_max, input logic rdy);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        for (int i = 0; i < g; i++) begin
            rx_bit_valid = 1'b0;
            rx_bit       = 1'($urandom);
            tick();
        end
        rx_bit       = b;
        rx_bit_valid = 1'b1;
        out_ready    = rdy;
        tick();
        rx_bit_valid = 1'b0;
        rx_bit       = 1'b1;
        out_ready    = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic stop, input int gap_max,
                              input logic rdy_at_stop);
        send_bit(1'b0, gap_max, 1'b0);
        for (int i = 7; i >= 0; i--) send_bit(code[i], gap_max, 1'b0);
        send_bit(stop, gap_max, rdy_at_stop);
    endtask

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + CW'(1);
    endfunction

    task automatic model_count(input logic [1:0] err);
        if (err == 2'b01) exp_corr = sat_inc(exp_corr);
        if (err == 2'b10) exp_uncorr = sat_inc(exp_uncorr);
    endtask

    task automatic chk_result(input string tag, input logic [3:0] d, input logic [2:0] s,
                              input logic [1:0] e);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".data"}, 32'(out_data), 32'(d));
        chk({tag, ".syn"}, 32'(out_syndrome), 32'(s));
        chk({tag, ".err"}, 32'(out_err), 32'(e));
        chk({tag, ".corr"}, 32'(corr_cnt), 32'(exp_corr));
        chk({tag, ".uncorr"}, 32'(uncorr_cnt), 32'(exp_uncorr));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_corr   = '0;
        exp_uncorr = '0;
    endtask

    initial begin
        vecs[0] = '{8'hAA, 4'hB, 3'b000, 2'b00};
        vecs[1] = '{8'h8A, 4'hB, 3'b101, 2'b01};
        vecs[2] = '{8'hAB, 4'hB, 3'b000, 2'b01};
        vecs[3] = '{8'h82, 4'h8, 3'b110, 2'b10};
        vecs[4] = '{8'h00, 4'h0, 3'b000, 2'b00};
        vecs[5] = '{8'hFF, 4'hF, 3'b000, 2'b00};
        vecs[6] = '{8'hFE, 4'hF, 3'b000, 2'b01};
        vecs[7] = '{8'h7F, 4'hF, 3'b111, 2'b01};
        vecs[8] = '{8'h03, 4'h0, 3'b001, 2'b10};

        do_reset();
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.data", 32'(out_data), 32'd0);
        chk("rst.syn", 32'(out_syndrome), 32'd0);
        chk("rst.err", 32'(out_err), 32'd0);
        chk("rst.ferr", 32'(frame_err), 32'd0);
        chk("rst.ovf", 32'(overflow), 32'd0);
        chk("rst.corr", 32'(corr_cnt), 32'd0);
        chk("rst.uncorr", 32'(uncorr_cnt), 32'd0);

        // Each frame follows the previous release immediately; counters saturate at 3.
        foreach (vecs[k]) begin
            send_frame(vecs[k].code, 1'b1, 0, 1'b0);
            model_count(vecs[k].err);
            chk_result($sformatf("vec%0d", k), vecs[k].data, vecs[k].syn, vecs[k].err);
            chk($sformatf("vec%0d.ovf", k), 32'(overflow), 32'd0);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk($sformatf("vec%0d.release", k), 32'(out_valid), 32'd0);
        end
        chk("sat.corr", 32'(corr_cnt), 32'(CMAX));

        do_reset();
        send_frame(8'h8A, 1'b1, 0, 1'b0);
        model_count(2'b01);
        chk("bp.first.ovf", 32'(overflow), 32'd0);
        send_frame(8'h82, 1'b1, 0, 1'b0);
        chk_result("bp.held", 4'hB, 3'b101, 2'b01);
        chk("bp.ovf", 32'(overflow), 32'd1);
        send_frame(8'hAB, 1'b1, 0, 1'b1);
        model_count(2'b01);
        chk_result("bp.replace", 4'hB, 3'b000, 2'b01);
        chk("bp.ovf.sticky", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        send_frame(8'hAA, 1'b0, 0, 1'b0);
        chk("ferr.pulse", 32'(frame_err), 32'd1);
        chk("ferr.valid", 32'(out_valid), 32'd0);
        tick();
        chk("ferr.clear", 32'(frame_err), 32'd0);
        chk("ferr.corr", 32'(corr_cnt), 32'(exp_corr));
        chk("ferr.uncorr", 32'(uncorr_cnt), 32'(exp_uncorr));

        send_frame(8'hAA, 1'b1, 3, 1'b0);
        chk_result("gap", 4'hB, 3'b000, 2'b00);

        send_bit(1'b0, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        send_bit(1'b0, 0, 1'b0);
        send_bit(1'b1, 0, 1'b0);
        send_bit(1'b0, 0, 1'b0);
        do_reset();
        chk("mrst.valid", 32'(out_valid), 32'd0);
        chk("mrst.data", 32'(out_data), 32'd0);
        chk("mrst.syn", 32'(out_syndrome), 32'd0);
        chk("mrst.err", 32'(out_err), 32'd0);
        chk("mrst.ovf", 32'(overflow), 32'd0);
        chk("mrst.corr", 32'(corr_cnt), 32'd0);
        chk("mrst.uncorr", 32'(uncorr_cnt), 32'd0);
        send_frame(8'hAA, 1'b1, 0, 1'b0);
        chk_result("mrst.next", 4'hB, 3'b000, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
